// File: rtl/iter_shifter.sv
// ---------------------------------------------------------------------------
// iter_shifter
// Multi-cycle shift/rotate unit for the execute stage. It shifts the operand
// by at most STEP bits per clock, so a full shift of in_amt bits takes
// ceil(in_amt/STEP) cycles. Requests and results use valid/ready handshakes,
// and only one request is in flight at a time.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous active-high reset
//   in_valid   request present
//   in_ready   unit idle and able to accept a request
//   in_data    operand [WIDTH-1:0]
//   in_amt     unsigned shift amount [AW-1:0]
//   in_op      00 ROL, 01 SLL, 10 SRA, 11 SRL
//   out_valid  result available
//   out_ready  consumer takes the result
//   out_data   registered result [WIDTH-1:0]
//   busy       high while shifting or holding a result
// ---------------------------------------------------------------------------
module iter_shifter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // Amount-sized constants carry one extra bit so that STEP == WIDTH and the
  // rotate complement (WIDTH - k) are representable.
  localparam logic [AW:0] STEP_W  = (AW+1)'(STEP);
  localparam logic [AW:0] WIDTH_W = (AW+1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] data_r;
  logic [AW-1:0]    rem_r;
  logic [1:0]       op_r;

  logic [AW:0]      k_s;
  logic [AW-1:0]    rem_next_s;
  logic [WIDTH-1:0] step_data_s;

  // One partial shift of d by k bits (0 <= k <= STEP) in the selected mode.
  // Rotating by k == 0 works because d >> WIDTH yields zero.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [AW:0]      k,
    input logic [1:0]       op
  );
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = (d << k) | (d >> (WIDTH_W - k));
      2'b01:   r = d << k;
      2'b10:   r = WIDTH'($signed(d) >>> k);
      2'b11:   r = d >> k;
      default: r = d;
    endcase
    return r;
  endfunction

  // Step size for this cycle and the resulting partial shift.
  // With STEP == WIDTH the remaining count is always below STEP, so k never
  // exceeds AW bits when it is subtracted from rem.
  always_comb begin
    k_s         = {(AW+1){1'b0}};
    rem_next_s  = rem_r;
    step_data_s = data_r;
    if ({1'b0, rem_r} >= STEP_W) begin
      k_s = STEP_W;
    end else begin
      k_s = {1'b0, rem_r};
    end
    rem_next_s  = rem_r - k_s[AW-1:0];
    step_data_s = shift_step(data_r, k_s, op_r);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      data_r  <= {WIDTH{1'b0}};
      rem_r   <= {AW{1'b0}};
      op_r    <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r <= in_data;
            rem_r  <= in_amt;
            op_r   <= in_op;
            if (in_amt == {AW{1'b0}}) begin
              state_r <= DONE;
            end else begin
              state_r <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_r <= step_data_s;
          rem_r  <= rem_next_s;
          if (rem_next_s == {AW{1'b0}}) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          // Result held until the consumer takes it; in_ready only rises
          // in the following cycle.
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs are decoded straight from the state register.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out_data  = data_r;

endmodule

// File: tb/tb_iter_shifter.sv
// ---------------------------------------------------------------------------
// tb_iter_shifter
// Self-checking bench for iter_shifter. Three instances (STEP = 4, 1, 16)
// with WIDTH = 16 are exercised through directed cases and random requests,
// and are compared against a whole-shift reference model.
// ---------------------------------------------------------------------------
module tb_iter_shifter;

  localparam int W = 16;

  logic clk;
  logic rst;

  logic [2:0] in_valid_v;
  logic [2:0] in_ready_v;
  logic [2:0] out_valid_v;
  logic [2:0] out_ready_v;
  logic [2:0] busy_v;
  logic [W-1:0] in_data_a  [3];
  logic [3:0]   in_amt_a   [3];
  logic [1:0]   in_op_a    [3];
  logic [W-1:0] out_data_a [3];

  int n_checks;
  int n_errors;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    iter_shifter #(.WIDTH(W), .STEP(S)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_data   (in_data_a[g]),
      .in_amt    (in_amt_a[g]),
      .in_op     (in_op_a[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_data  (out_data_a[g]),
      .busy      (busy_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int step_of(input int u);
    return (u == 0) ? 4 : ((u == 1) ? 1 : 16);
  endfunction

  // Reference: the whole shift done in one go from the mode definitions.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d,
                                             input int a,
                                             input logic [1:0] op);
    logic [2*W-1:0] dd;
    logic [W-1:0]   r;
    int             v;
    dd = {d, d} << a;
    case (op)
      2'b00:   r = dd[2*W-1:W];
      2'b01:   r = d << a;
      2'b10: begin
        v = int'($signed(d));
        r = W'(v >>> a);
      end
      default: r = d >> a;
    endcase
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge to an idle unit; returns at the negedge
  // after the accepting edge with in_valid dropped.
  task automatic issue(input int u, input logic [W-1:0] d,
                       input logic [3:0] a, input logic [1:0] op);
    check_val("in_ready_idle", 32'(in_ready_v[u]), 32'd1);
    in_valid_v[u] = 1'b1;
    in_data_a[u]  = d;
    in_amt_a[u]   = a;
    in_op_a[u]    = op;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[u] = 1'b0;
  endtask

  // Wait for out_valid; edges counts posedges since (and including) accept.
  task automatic wait_result(input int u, input logic [W-1:0] exp,
                             input int lat);
    int edges;
    edges = 1;
    while (!out_valid_v[u] && edges < 64) begin
      check_val("in_ready_busy", 32'(in_ready_v[u]), 32'd0);
      @(negedge clk);
      edges++;
    end
    check_val("result_timeout", 32'(out_valid_v[u]), 32'd1);
    check_val("latency", 32'(edges), 32'(lat + 1));
    check_val("result_data", 32'(out_data_a[u]), 32'(exp));
    check_val("busy_done", 32'(busy_v[u]), 32'd1);
    check_val("in_ready_done", 32'(in_ready_v[u]), 32'd0);
  endtask

  // Hold the result for a number of stalled cycles, then consume it.
  task automatic drain(input int u, input logic [W-1:0] exp, input int stall);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(out_valid_v[u]), 32'd1);
      check_val("hold_data", 32'(out_data_a[u]), 32'(exp));
    end
    out_ready_v[u] = 1'b1;
    @(negedge clk);
    out_ready_v[u] = 1'b0;
    check_val("post_valid", 32'(out_valid_v[u]), 32'd0);
    check_val("post_ready", 32'(in_ready_v[u]), 32'd1);
    check_val("post_data", 32'(out_data_a[u]), 32'(exp));
  endtask

  task automatic run_one(input int u, input logic [W-1:0] d,
                         input logic [3:0] a, input logic [1:0] op,
                         input int stall);
    logic [W-1:0] e;
    int s;
    e = ref_shift(d, int'(a), op);
    s = step_of(u);
    issue(u, d, a, op);
    wait_result(u, e, (int'(a) + s - 1) / s);
    drain(u, e, stall);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    in_valid_v  = 3'b000;
    out_ready_v = 3'b000;
    for (int u = 0; u < 3; u++) begin
      in_data_a[u] = '0;
      in_amt_a[u]  = '0;
      in_op_a[u]   = '0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check_val("rst_data", 32'(out_data_a[u]), 32'd0);
      check_val("rst_valid", 32'(out_valid_v[u]), 32'd0);
      check_val("rst_ready", 32'(in_ready_v[u]), 32'd1);
      check_val("rst_busy", 32'(busy_v[u]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed cases on the STEP=4 unit.
    run_one(0, 16'h1234, 4'd4, 2'b00, 0);
    check_val("rol_1234_4", 32'(out_data_a[0]), 32'h2341);
    run_one(0, 16'h8001, 4'd5, 2'b01, 1);
    check_val("sll_8001_5", 32'(out_data_a[0]), 32'h0020);
    run_one(0, 16'h8000, 4'd15, 2'b11, 0);
    check_val("srl_8000_15", 32'(out_data_a[0]), 32'h0001);
    run_one(0, 16'h8000, 4'd15, 2'b10, 2);
    check_val("sra_8000_15", 32'(out_data_a[0]), 32'hFFFF);
    run_one(0, 16'h7FF0, 4'd4, 2'b10, 0);
    check_val("sra_7ff0_4", 32'(out_data_a[0]), 32'h07FF);
    run_one(0, 16'h8001, 4'd15, 2'b00, 0);
    check_val("rol_8001_15", 32'(out_data_a[0]), 32'hC000);

    // Pass-through with a held result and a pending request that must wait.
    issue(0, 16'hA5A5, 4'd0, 2'b10);
    wait_result(0, 16'hA5A5, 0);
    in_valid_v[0] = 1'b1;
    in_data_a[0]  = 16'h1111;
    in_amt_a[0]   = 4'd3;
    in_op_a[0]    = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("amt0_hold_data", 32'(out_data_a[0]), 32'hA5A5);
      check_val("amt0_hold_valid", 32'(out_valid_v[0]), 32'd1);
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    check_val("amt0_idle_ready", 32'(in_ready_v[0]), 32'd1);
    check_val("amt0_idle_valid", 32'(out_valid_v[0]), 32'd0);
    check_val("amt0_idle_data", 32'(out_data_a[0]), 32'hA5A5);
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    wait_result(0, 16'h8888, 1);
    drain(0, 16'h8888, 0);

    // Asynchronous reset in the middle of a shift.
    issue(0, 16'hFFFF, 4'd13, 2'b01);
    repeat (2) @(negedge clk);
    check_val("mid_busy", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_val("arst_data", 32'(out_data_a[0]), 32'd0);
    check_val("arst_valid", 32'(out_valid_v[0]), 32'd0);
    check_val("arst_ready", 32'(in_ready_v[0]), 32'd1);
    check_val("arst_busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("arst_stay_idle", 32'(out_valid_v[0]), 32'd0);
    run_one(0, 16'hF000, 4'd12, 2'b11, 0);
    check_val("srl_f000_12", 32'(out_data_a[0]), 32'h000F);

    // Random requests with random consumer stalls on all three step sizes.
    for (int u = 0; u < 3; u++) begin
      for (int n = 0; n < 50; n++) begin
        run_one(u, W'($urandom), 4'($urandom_range(15, 0)),
                2'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Parametrised, multi-cycle shift/rotate unit for the execute stage.
- Replaces the fixed chain of shift-by-1/2/4/8 stages with one registered datapath that shifts STEP bits per cycle.
- Supports any shift amount from 0 to WIDTH-1 in all four shift/rotate modes.
- Uses valid/ready handshakes on input and output so the control unit can stall around it.

Parameters:
- WIDTH, 16, data width in bits; must be a power of 2, ≥4.
- STEP, 4, maximum bits shifted per cycle; must be a power of 2, 1 ≤ STEP ≤ WIDTH.
- AW, log2(WIDTH), width of the shift-amount field; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- in_data  in  WIDTH  operand.
- in_amt  in  AW  shift amount, unsigned.
- in_op  in  2  mode: 00 rotate left, 01 shift left logical, 10 shift right arithmetic, 11 shift right logical.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  WIDTH  result, registered.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (async, any state, including mid-SHIFT):
  - State goes to IDLE.
  - out_data=0, out_valid=0, in_ready=1, busy=0.
  - Internal remaining count and op register are cleared.
  - No partial result is ever presented after reset.
- Accept: at an edge with state IDLE and in_valid=1:
  - Latch in_data into the data register (drives out_data).
  - Latch in_amt into rem and in_op into op.
  - Next state is DONE if in_amt=0, else SHIFT.
  - in_valid while not IDLE is ignored; no request is queued.
- SHIFT step, each edge:
  - k = STEP if rem ≥ STEP, else k = rem.
  - Data register ← data shifted by k per op; rem ← rem − k.
  - If the new rem = 0, next state is DONE.
- Shift semantics per step:
  - Rotate left: bits leaving the MSB re-enter at the LSB.
  - SLL: zero fill at the LSB.
  - SRA: fill with the current MSB.
  - SRL: zero fill at the MSB.
- Step composition: successive steps compose exactly. The final result equals a single shift of the original operand by in_amt, including SRA sign replication and rotate wrap-around at WIDTH.
- Latency: if accept is at edge t, out_valid is high after edge t+ceil(in_amt/STEP).
  - in_amt=0: result after edge t (a pure pass-through).
  - Maximum is ceil((WIDTH−1)/STEP) cycles.
- DONE:
  - out_data and out_valid are held stable until out_ready=1 at an edge; then next state is IDLE.
  - out_ready while out_valid=0 has no effect.
- Throughput: at most one request in flight. in_ready is not asserted in the same cycle that DONE is consumed; a new accept is possible at the earliest one edge after the handshake.
- out_data holds the last result in IDLE and updates only on accept/step.
- STEP=WIDTH degenerates to a single-cycle-step shifter with 1-cycle latency for nonzero amounts.
- No combinational path from in_* to out_*; all outputs come from registers or decoded state.

Test Plan:
- WIDTH=16, STEP=4: ROL 0x1234 by 4 → 0x2341; out_valid high exactly 1 edge after accept; in_ready low during busy.
- SLL 0x8001 by 5 → 0x0020 after 2 shift edges; SRL 0x8000 by 15 → 0x0001 after 4 shift edges.
- SRA 0x8000 by 15 → 0xFFFF; SRA 0x7FF0 by 4 → 0x07FF; ROL 0x8001 by 15 → 0xC000.
- Amount 0, any op, in_data 0xA5A5 → out_data 0xA5A5, out_valid after 1 edge; then hold out_ready=0 for 3 cycles with in_valid=1 and new data → out_data stays 0xA5A5, no second accept; out_ready=1 → IDLE next edge, then the new request is accepted.
- Assert rst mid-SHIFT (SLL 0xFFFF by 13, after 2 steps) → out_data=0, out_valid=0, in_ready=1 immediately (async); deassert rst, new request SRL 0xF000 by 12 → 0x000F.
- Back-to-back: 50 random {data, amt, op} with random out_ready stalls, compared against a reference model; also rerun with STEP=1 and STEP=16 → results match, latencies equal ceil(amt/STEP).
